// File: rtl/jtag_uart_avalon_poller.sv
// Avalon-MM master polling the JTAG-UART: RX bytes become one-cycle strobes,
// and with JTAG_UART_TX_EN defined a small TX FIFO is drained to the host.
module jtag_uart_avalon_poller #(
  parameter int POLL_INTERVAL = 16,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oJTAG_SLAVE_ADDR,
  output logic        oJTAG_SLAVE_RDREQ,
  input  logic [31:0] iJTAG_SLAVE_RDDATA,
  output logic        oJTAG_SLAVE_WRREQ,
  output logic [31:0] oJTAG_SLAVE_WRDATA,
  input  logic        iJTAG_SLAVE_WAIT,
  output logic [7:0]  oDATA_TO_PARSE,
  output logic        oDATA_TO_PARSE_VALID,
  input  logic [7:0]  iTX_BYTE,
  input  logic        iTX_BYTE_VALID,
  output logic        oTX_READY
);
  typedef enum logic [2:0] {IDLE, RD_DATA, RX_OUT, RD_CTRL, WR_DATA} state_t;

  localparam logic [15:0] RELOAD = 16'(POLL_INTERVAL);

  state_t      state;
  logic [15:0] poll_cnt;
  logic        tx_turn;
  logic        more_rx;
  logic        tx_pending;
  logic        tx_go;
  logic        unused_rd_bits;

  assign unused_rd_bits = ^iJTAG_SLAVE_RDDATA[14:8];
  assign tx_go = tx_turn & tx_pending;

`ifdef JTAG_UART_TX_EN
  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    fifo [TX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          push, pop, tx_ready;
  logic          wr_q;
  logic [7:0]    wbyte;

  assign push       = iTX_BYTE_VALID & tx_ready;
  assign pop        = (state == WR_DATA) & ~iJTAG_SLAVE_WAIT;
  assign count_nx   = count + CW'(push) - CW'(pop);
  assign tx_pending = (count != '0);
  assign oTX_READY  = tx_ready;
  assign oJTAG_SLAVE_WRREQ  = wr_q;
  assign oJTAG_SLAVE_WRDATA = {24'd0, wbyte};

  // Ready is registered from the next count so it always equals "not full".
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nx;
      tx_ready <= (count_nx < CW'(TX_FIFO_DEPTH));
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) fifo[wr_ptr] <= iTX_BYTE;
  end
`else
  logic unused_tx;
  assign unused_tx  = ^{iTX_BYTE, iTX_BYTE_VALID, TX_FIFO_DEPTH[0]};
  assign tx_pending = 1'b0;
  assign oTX_READY  = 1'b0;
  assign oJTAG_SLAVE_WRREQ  = 1'b0;
  assign oJTAG_SLAVE_WRDATA = 32'd0;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state                <= IDLE;
      poll_cnt             <= '0;
      tx_turn              <= 1'b0;
      more_rx              <= 1'b0;
      oJTAG_SLAVE_ADDR     <= 1'b0;
      oJTAG_SLAVE_RDREQ    <= 1'b0;
      oDATA_TO_PARSE       <= '0;
      oDATA_TO_PARSE_VALID <= 1'b0;
`ifdef JTAG_UART_TX_EN
      wr_q                 <= 1'b0;
      wbyte                <= '0;
`endif
    end else begin
      oDATA_TO_PARSE_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (poll_cnt != 16'd0) poll_cnt <= poll_cnt - 16'd1;
          // A count of 1 dispatches too, so a reload gives exactly POLL_INTERVAL idle cycles.
          if (poll_cnt <= 16'd1) begin
            oJTAG_SLAVE_RDREQ <= 1'b1;
            if (tx_go) begin
              state            <= RD_CTRL;
              oJTAG_SLAVE_ADDR <= 1'b1;
            end else begin
              state            <= RD_DATA;
              oJTAG_SLAVE_ADDR <= 1'b0;
            end
          end
        end
        RD_DATA: if (!iJTAG_SLAVE_WAIT) begin
          oJTAG_SLAVE_RDREQ <= 1'b0;
          oDATA_TO_PARSE    <= iJTAG_SLAVE_RDDATA[7:0];
          more_rx           <= (iJTAG_SLAVE_RDDATA[31:16] > 16'd1);
          if (iJTAG_SLAVE_RDDATA[15]) begin
            state                <= RX_OUT;
            oDATA_TO_PARSE_VALID <= 1'b1;
          end else begin
            state    <= IDLE;
            poll_cnt <= RELOAD;
            tx_turn  <= ~tx_turn;
          end
        end
        RX_OUT: begin
          poll_cnt <= more_rx ? 16'd0 : RELOAD;
          tx_turn  <= ~tx_turn;
          state    <= IDLE;
        end
`ifdef JTAG_UART_TX_EN
        RD_CTRL: if (!iJTAG_SLAVE_WAIT) begin
          oJTAG_SLAVE_RDREQ <= 1'b0;
          if (iJTAG_SLAVE_RDDATA[31:16] != 16'd0) begin
            state            <= WR_DATA;
            oJTAG_SLAVE_ADDR <= 1'b0;
            wr_q             <= 1'b1;
            wbyte            <= fifo[rd_ptr];
          end else begin
            state    <= IDLE;
            poll_cnt <= RELOAD;
            tx_turn  <= ~tx_turn;
          end
        end
        WR_DATA: if (!iJTAG_SLAVE_WAIT) begin
          wr_q    <= 1'b0;
          tx_turn <= ~tx_turn;
          state   <= IDLE;
        end
`endif
        default: begin
          oJTAG_SLAVE_RDREQ <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_uart_avalon_poller.sv
// Directed bench for jtag_uart_avalon_poller: table of RX read responses plus
// hand sequences for waitrequest bursts, TX draining and reset mid-write.
module tb_jtag_uart_avalon_poller;
  logic        clk = 1'b0, rst = 1'b1;
  logic        addr, rdreq, wrreq, valid, tx_ready;
  logic        wt = 1'b0, tx_valid = 1'b0;
  logic [31:0] rddata = 32'd0, wrdata;
  logic [7:0]  data, tx_byte = 8'd0;
  int          passed = 0, total = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jtag_uart_avalon_poller #(.POLL_INTERVAL(16), .TX_FIFO_DEPTH(4)) dut (
    .iCLK(clk), .iRST(rst),
    .oJTAG_SLAVE_ADDR(addr), .oJTAG_SLAVE_RDREQ(rdreq), .iJTAG_SLAVE_RDDATA(rddata),
    .oJTAG_SLAVE_WRREQ(wrreq), .oJTAG_SLAVE_WRDATA(wrdata), .iJTAG_SLAVE_WAIT(wt),
    .oDATA_TO_PARSE(data), .oDATA_TO_PARSE_VALID(valid),
    .iTX_BYTE(tx_byte), .iTX_BYTE_VALID(tx_valid), .oTX_READY(tx_ready)
  );

  typedef struct {bit wr; bit a; logic [31:0] wd; int cyc;} txn_t;
  typedef struct {logic [7:0] b; int cyc;} strb_t;
  typedef struct {logic [31:0] rd; bit strobe; logic [7:0] b; int gap;} vec_t;

  txn_t        txns[$];
  strb_t       strobes[$];
  logic [31:0] rsp_data[$], rsp_ctrl[$];
  int          wait_n = 0, wleft = 0, stab_err = 0, wr_hi = 0, rdy_hi = 0;
  bit          active = 1'b0;
  logic [34:0] snap;

  // Slave responder and monitor: wait_n wait cycles per transaction, then complete.
  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
      wt = 1'b0;
    end else if (rdreq || wrreq) begin
      if (!active) begin
        active = 1'b1;
        wleft = wait_n;
        snap = {addr, rdreq, wrreq, wrdata};
      end else if (snap !== {addr, rdreq, wrreq, wrdata}) stab_err++;
      if (wleft > 0) begin
        wt = 1'b1;
        wleft--;
      end else begin
        wt = 1'b0;
        active = 1'b0;
        if (rdreq) begin
          if (addr) begin
            if (rsp_ctrl.size() > 0) rddata = rsp_ctrl.pop_front();
            else rddata = 32'd0;
          end else begin
            if (rsp_data.size() > 0) rddata = rsp_data.pop_front();
            else rddata = 32'd0;
          end
        end
        txns.push_back('{wrreq, addr, wrdata, cyc});
      end
    end else begin
      if (active) stab_err++;
      active = 1'b0;
      wt = 1'b0;
    end
    if (!rst) begin
      if (valid) strobes.push_back('{data, cyc});
      if (wrreq) wr_hi++;
      if (tx_ready) rdy_hi++;
    end
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tx_valid = 1'b0;
    wait_n = 0;
    rsp_data.delete();
    rsp_ctrl.delete();
    repeat (2) @(negedge clk);
    txns.delete();
    strobes.delete();
    stab_err = 0;
    wr_hi = 0;
    rdy_hi = 0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_txns(int n, int budget, string name);
    int k = 0;
    while (txns.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (txns.size() < n) check({name, "_timeout"}, 64'(txns.size()), 64'(n));
  endtask

  task automatic push(logic [7:0] b);
    @(negedge clk);
    tx_byte = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  vec_t vt[9];
  int   si;

  initial begin
    vt[0] = '{32'h0001_8041, 1'b1, 8'h41, 18};
    vt[1] = '{32'h0003_80FE, 1'b1, 8'hFE, 3};
    vt[2] = '{32'h0002_8001, 1'b1, 8'h01, 3};
    vt[3] = '{32'h0001_8055, 1'b1, 8'h55, 18};
    vt[4] = '{32'h0000_0000, 1'b0, 8'h00, 17};
    vt[5] = '{32'h0000_7F99, 1'b0, 8'h00, 17};
    vt[6] = '{32'h0005_0077, 1'b0, 8'h00, 17};
    vt[7] = '{32'hFFFF_80C3, 1'b1, 8'hC3, 3};
    vt[8] = '{32'h0001_8000, 1'b1, 8'h00, 18};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_rdreq", 64'(rdreq), 64'd0);
    check("rst_wrreq", 64'(wrreq), 64'd0);
    check("rst_wrdata", 64'(wrdata), 64'd0);
    check("rst_data", 64'({data, valid}), 64'd0);
`ifdef JTAG_UART_TX_EN
    check("rst_tx_ready", 64'(tx_ready), 64'd1);
`else
    check("rst_tx_ready", 64'(tx_ready), 64'd0);
`endif

    // Table of data-register responses, no waitrequest
    do_reset();
    foreach (vt[i]) rsp_data.push_back(vt[i].rd);
    release_rst();
    @(posedge clk);
    #1 check("first_rdreq_addr0", 64'({addr, rdreq}), 64'b01);
    wait_txns(10, 3000, "table");
    si = 0;
    for (int i = 0; i < 9; i++) begin
      if (txns.size() > i + 1) begin
        check($sformatf("v%0d_data_read", i), 64'({txns[i].wr, txns[i].a}), 64'b00);
        check($sformatf("v%0d_gap", i), 64'(txns[i+1].cyc - txns[i].cyc), 64'(vt[i].gap));
      end
      if (vt[i].strobe) begin
        if (si < strobes.size() && txns.size() > i) begin
          check($sformatf("v%0d_byte", i), 64'(strobes[si].b), 64'(vt[i].b));
          check($sformatf("v%0d_latency", i), 64'(strobes[si].cyc - txns[i].cyc), 64'd1);
        end else check($sformatf("v%0d_strobe_present", i), 64'd0, 64'd1);
        si++;
      end
    end
    check("table_strobe_count", 64'(strobes.size()), 64'd6);

    // Burst with two wait cycles per read
    do_reset();
    wait_n = 2;
    rsp_data.push_back(32'h0003_80FE);
    rsp_data.push_back(32'h0002_8001);
    rsp_data.push_back(32'h0001_8055);
    release_rst();
    wait_txns(4, 300, "burst");
    check("burst_count", 64'(strobes.size()), 64'd3);
    if (strobes.size() == 3)
      check("burst_bytes", 64'({strobes[0].b, strobes[1].b, strobes[2].b}), 64'hFE0155);
    if (txns.size() >= 4) begin
      check("burst_gap0", 64'(txns[1].cyc - txns[0].cyc), 64'd5);
      check("burst_gap1", 64'(txns[2].cyc - txns[1].cyc), 64'd5);
      check("burst_gap2", 64'(txns[3].cyc - txns[2].cyc), 64'd20);
    end
    check("burst_hold_stable", 64'(stab_err), 64'd0);

`ifdef JTAG_UART_TX_EN
    // TX: first control read reports no space, retry writes both bytes in order
    begin
      int c0, nw;
      logic [7:0] wb[$];
      do_reset();
      rsp_ctrl.push_back(32'h0000_0000);
      rsp_ctrl.push_back(32'h0040_0000);
      rsp_ctrl.push_back(32'h0040_0000);
      release_rst();
      push(8'hA5);
      push(8'h5A);
      repeat (200) @(negedge clk);
      c0 = -1;
      nw = 0;
      foreach (txns[i]) begin
        if (c0 < 0 && !txns[i].wr && txns[i].a) c0 = i;
        if (txns[i].wr) begin
          nw++;
          wb.push_back(txns[i].wd[7:0]);
          check($sformatf("tx_wr%0d_word", nw), 64'({txns[i].a, txns[i].wd[31:8]}), 64'd0);
        end
      end
      if (c0 >= 0 && c0 + 1 < txns.size())
        check("tx_no_write_on_wspace0", 64'(txns[c0+1].wr), 64'd0);
      else check("tx_ctrl_read_seen", 64'd0, 64'd1);
      check("tx_write_count", 64'(nw), 64'd2);
      if (wb.size() == 2) check("tx_write_bytes", 64'({wb[0], wb[1]}), 64'hA55A);
      check("tx_hold_stable", 64'(stab_err), 64'd0);
    end

    // TX full: four pushes fill the FIFO, the fifth is dropped
    begin
      logic [31:0] got;
      do_reset();
      release_rst();
      push(8'h01);
      push(8'h02);
      push(8'h03);
      check("ready_after_3", 64'(tx_ready), 64'd1);
      push(8'h04);
      check("ready_after_4", 64'(tx_ready), 64'd0);
      push(8'h05);
      check("ready_after_drop", 64'(tx_ready), 64'd0);
      check("no_write_without_space", 64'(wr_hi), 64'd0);
      repeat (5) rsp_ctrl.push_back(32'h0040_0000);
      repeat (300) @(negedge clk);
      got = 32'd0;
      si = 0;
      foreach (txns[i]) if (txns[i].wr) begin
        got = {got[23:0], txns[i].wd[7:0]};
        si++;
      end
      check("full_write_count", 64'(si), 64'd4);
      check("full_write_bytes", 64'(got), 64'h01020304);
      check("ready_after_drain", 64'(tx_ready), 64'd1);
    end

    // Reset while a write is stalled by waitrequest
    begin
      int k = 0;
      do_reset();
      wait_n = 5;
      rsp_ctrl.push_back(32'h0040_0000);
      release_rst();
      push(8'h33);
      while (!(wrreq && wt) && k < 500) begin
        @(negedge clk);
        #1;
        k++;
      end
      check("midwr_reached", 64'(wrreq && wt), 64'd1);
      rst = 1'b1;
      #1;
      check("midwr_wrreq_drop", 64'({wrreq, rdreq}), 64'd0);
      check("midwr_tx_ready", 64'(tx_ready), 64'd1);
      repeat (2) @(negedge clk);
      txns.delete();
      strobes.delete();
      rsp_ctrl.delete();
      rsp_ctrl.push_back(32'h0040_0000);
      wait_n = 0;
      wr_hi = 0;
      release_rst();
      @(posedge clk);
      #1 check("midwr_first_req", 64'({addr, rdreq, wrreq}), 64'b010);
      repeat (150) @(negedge clk);
      check("midwr_fifo_empty", 64'(wr_hi), 64'd0);
    end
`else
    // Without the TX path pushes are ignored across 100 polls
    begin
      int nw = 0;
      do_reset();
      release_rst();
      tx_byte = 8'h77;
      tx_valid = 1'b1;
      wait_txns(100, 2500, "notx");
      tx_valid = 1'b0;
      foreach (txns[i]) if (txns[i].wr || txns[i].a) nw++;
      check("notx_only_data_reads", 64'(nw), 64'd0);
      check("notx_wrreq_low", 64'(wr_hi), 64'd0);
      check("notx_tx_ready_low", 64'(rdy_hi), 64'd0);
      check("notx_wrdata_zero", 64'(wrdata), 64'd0);
      check("notx_no_strobes", 64'(strobes.size()), 64'd0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/jtag_uart_avalon_poller.md
# jtag_uart_avalon_poller

Avalon-MM master that services the JTAG-UART core on behalf of the host-command decoder. It polls the UART data register, strips the Avalon status fields and presents each received byte as a one-cycle `oDATA_TO_PARSE_VALID` pulse to the downstream escape/instruction decoder. It also drains a small transmit FIFO back to the host, gated on the UART's reported write space.

## Interface
Parameters:
- POLL_INTERVAL, 16: idle cycles between polls when the RX FIFO was last seen empty; 1..65535.
- TX_FIFO_DEPTH, 4: transmit FIFO entries; power of two, 2..16.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  reset, asynchronous, active-high.
- oJTAG_SLAVE_ADDR  out  1  0 = data register, 1 = control register.
- oJTAG_SLAVE_RDREQ  out  1  Avalon read.
- iJTAG_SLAVE_RDDATA  in  32  Avalon readdata; valid in the cycle the read completes.
- oJTAG_SLAVE_WRREQ  out  1  Avalon write.
- oJTAG_SLAVE_WRDATA  out  32  Avalon writedata; {24'd0, byte}.
- iJTAG_SLAVE_WAIT  in  1  Avalon waitrequest.
- oDATA_TO_PARSE  out  8  received byte.
- oDATA_TO_PARSE_VALID  out  1  one-cycle strobe per received byte.
- iTX_BYTE  in  8  byte to send to the host.
- iTX_BYTE_VALID  in  1  push `iTX_BYTE`; ignored when `oTX_READY` = 0.
- oTX_READY  out  1  TX FIFO not full.

## Operation
- FSM states: IDLE, RD_DATA, RX_OUT, RD_CTRL, WR_DATA.
- A transaction completes in the cycle where its request is high and `iJTAG_SLAVE_WAIT` = 0.
- While `iJTAG_SLAVE_WAIT` = 1, the address, request and write data are held unchanged.
- IDLE:
  - Decrements the poll counter.
  - When the counter is 0: go to RD_DATA if the last RX poll result was "empty", otherwise go there immediately.
  - RX has priority on odd turns and TX on even turns (round-robin toggle). A TX turn is taken only if the FIFO is non-empty; otherwise the turn passes to RX.
- RD_DATA:
  - Drives addr 0 with rdreq.
  - On completion, latch bits[7:0] and RVALID = bit15 (RAVAIL = bits[31:16]).
  - If RVALID = 1, go to RX_OUT. Otherwise reload the poll counter to POLL_INTERVAL, flip the turn and return to IDLE.
- RX_OUT:
  - Drives `oDATA_TO_PARSE_VALID` = 1 for exactly one cycle, with the byte held.
  - If RAVAIL > 1, skip the poll delay: the counter is 0 and the next RX turn is immediate.
  - Flip the turn and go to IDLE.
- RD_CTRL:
  - Drives addr 1 with rdreq.
  - On completion, if WSPACE (bits[31:16]) ≠ 0, go to WR_DATA.
  - Otherwise reload the poll counter, flip the turn and go to IDLE; the byte stays in the FIFO.
- WR_DATA:
  - Drives addr 0 with wrreq and data = FIFO head.
  - On completion, pop the FIFO, flip the turn and go to IDLE.
- Read and write requests are never asserted together.
- TX FIFO:
  - A push and a pop in the same cycle are both honoured.
  - A push when full is dropped.
  - The pointers wrap modulo TX_FIFO_DEPTH.
  - The count is $clog2(TX_FIFO_DEPTH)+1 bits wide.
- Received bytes have no backpressure: the consumer must accept every strobe.
- Reset mid-transaction: all requests drop immediately, FIFO contents are discarded, and the FSM restarts in IDLE with poll counter 0 and RX turn first.

## Timing
- Reset values:
  - all outputs 0, except `oTX_READY` = 1 (TX build);
  - FSM = IDLE;
  - poll counter = 0;
  - FIFO empty.
- The first RD_DATA request appears 1 cycle after reset release.
- Back-to-back RX: with wait = 0 and RAVAIL large, one byte every 3 cycles (RD_DATA, RX_OUT, IDLE).
- Latency from read completion to `oDATA_TO_PARSE_VALID`: 1 cycle.
- `oTX_READY` is registered: it deasserts in the cycle after the push that fills the FIFO.

## Configuration
- JTAG_UART_TX_EN defined: the TX FIFO, RD_CTRL and WR_DATA are present as above.
- JTAG_UART_TX_EN undefined:
  - FIFO and TX states are removed;
  - `oJTAG_SLAVE_WRREQ` = 0, `oJTAG_SLAVE_WRDATA` = 0 and `oTX_READY` = 0 constantly;
  - `iTX_BYTE*` are ignored;
  - every IDLE turn is an RX turn.

## Test plan
- Single byte: a data read returns 0x0001_8041 (RAVAIL = 1, RVALID = 1, byte 0x41) -> one strobe with 0x41; the next poll starts exactly POLL_INTERVAL = 16 idle cycles later.
- Burst with waitrequest: three reads return RAVAIL 3, 2, 1 with bytes 0xFE, 0x01, 0x55; wait is held high for 2 cycles on each -> three strobes in order, address/rdreq stable during wait, no poll delay between reads.
- Empty FIFO: readdata 0x0000_0000 -> no strobe, and rdreq re-asserts every 17 cycles.
- TX: push 0xA5, 0x5A; control reads return WSPACE 0 then 0x0040 -> no write after the first control read; the retry writes 0x0000_00A5 then 0x0000_005A; `oTX_READY` deasserts after 4 pushes with no pops and a 5th push is dropped.
- Reset mid-write: assert iRST while wrreq is high and wait = 1 -> wrreq is 0 in the same cycle, the FIFO is empty, and after release the first request is an addr-0 read.
- Without JTAG_UART_TX_EN: pushes are ignored and wrreq stays 0 through 100 polls.
